switch_debouncer: RTL
=====================

Name: switch_debouncer

Overview:
- Upstream conditioning stage for the 4-state switch-driven machine.
- Takes the raw, asynchronous, bouncing board switch and synchronizes it into clk.
- Filters it with a stability counter and presents a clean level plus single-cycle edge pulses.
- The clean level drives the state machine's sw input directly.

Parameters:
STABLE_CYCLES, 500000, consecutive synchronized samples of the new level required before accepting a change (10 ms at 50 MHz); legal range 1..2^CNT_WIDTH.
CNT_WIDTH, 20, width of the stability counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
sw_raw  input  1  raw switch pin, asynchronous to clk.
sw_clean  output  1  debounced level; feeds the state machine's sw input.
rise_pulse  output  1  one-cycle pulse when sw_clean goes 0->1.
fall_pulse  output  1  one-cycle pulse when sw_clean goes 1->0.
state_dbg  output  2  current FSM state encoding, for LEDs/debug.

Behaviour:
- Reset (reset=0, asynchronous, any time):
  - Both synchronizer flops = 0, counter = 0, state = STABLE_LOW.
  - sw_clean = 0, rise_pulse = 0, fall_pulse = 0, state_dbg = 2'b00.
  - Reset deassertion takes effect on the next rising clk.
- Synchronizer: two flops in series; sw_sync = sw_raw delayed 2 edges. Only sw_sync is used downstream.
- FSM states and encodings: STABLE_LOW 00, WAIT_HIGH 01, STABLE_HIGH 10, WAIT_LOW 11. state_dbg = state register.
- STABLE_LOW:
  - sw_sync=1 -> WAIT_HIGH, cnt<=0.
  - Otherwise hold.
- WAIT_HIGH:
  - sw_sync=0 -> STABLE_LOW, cnt<=0 (glitch rejected, no pulse).
  - Else if cnt==STABLE_CYCLES-1 -> STABLE_HIGH.
  - Else cnt<=cnt+1.
- STABLE_HIGH / WAIT_LOW: mirror images of the above with the levels inverted.
- Outputs:
  - sw_clean is registered: 1 in STABLE_HIGH and WAIT_LOW, 0 in STABLE_LOW and WAIT_HIGH.
  - rise_pulse is registered, high for exactly the one cycle in which the state first becomes STABLE_HIGH (coincident with sw_clean's first 1 cycle).
  - fall_pulse is the same for STABLE_LOW entry from WAIT_LOW.
  - rise_pulse and fall_pulse are never both high.
- Latency: a clean step on sw_raw that stays put reaches sw_clean on the (STABLE_CYCLES+3)th rising edge, counting the first edge that samples the new level.
- Counter:
  - Never exceeds STABLE_CYCLES-1.
  - No wrap-around.
  - Cleared on every entry to a WAIT state.
  - Value is don't-care in STABLE states.
- STABLE_CYCLES=1: WAIT state lasts exactly one cycle; latency 4 edges.
- A bounce at any point during WAIT restarts filtering from the STABLE state. The accepted level is never disturbed by pulses shorter than STABLE_CYCLES+1 samples.
- Reset mid-WAIT: state returns to STABLE_LOW and any pending change is discarded.
- Reset while in STABLE_HIGH: sw_clean drops to 0 immediately (asynchronous) with no fall_pulse. If sw_raw is still 1 after release, a normal rise is re-qualified.

Test Plan:
- Reset with sw_raw=0, release, hold 20 cycles (STABLE_CYCLES=8) -> sw_clean=0, no pulses, state_dbg=00 throughout.
- STABLE_CYCLES=8, sw_raw 0->1 at edge e0 and held -> sw_clean=1 and rise_pulse=1 for exactly one cycle after edge e10; state_dbg sequence 00,01,10.
- STABLE_CYCLES=8, bouncing high: sw_raw high 5 cycles, low 2, high 3, low 1, then high steady -> sw_clean rises only 11 edges after the final steady edge; exactly one rise_pulse.
- From STABLE_HIGH, sw_raw 1->0 held -> fall_pulse single cycle, sw_clean=0 after 11 edges; a 3-cycle low glitch instead -> sw_clean stays 1, no fall_pulse.
- Assert reset=0 midway through WAIT_HIGH (cnt=4), asynchronously between edges -> state_dbg=00 and sw_clean=0 before the next edge; after release with sw_raw=1, full 11-edge qualification repeats.
- STABLE_CYCLES=1: step on sw_raw -> sw_clean follows after 4 edges; a 1-cycle sw_raw pulse -> rejected, no edge pulses.

Source files
------------

// File: rtl/switch_debouncer_if.sv
// Switch-conditioning bundle: raw pin in, debounced level, edge pulses and state for debug.
interface switch_debouncer_if;
  logic       sw_raw;
  logic       sw_clean;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [1:0] state_dbg;

  modport master (
    output sw_raw,
    input  sw_clean,
    input  rise_pulse,
    input  fall_pulse,
    input  state_dbg
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output rise_pulse,
    output fall_pulse,
    output state_dbg
  );
endinterface

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer followed by a stability-counter FSM that turns a bouncing
// board switch into a clean level with single-cycle rise/fall pulses.
module switch_debouncer #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = 20
) (
  input logic               clk,
  input logic               reset,
  switch_debouncer_if.slave sw
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);

  logic                 sync1_r;
  logic                 sync2_r;
  state_t               state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 clean_r;
  logic                 rise_r;
  logic                 fall_r;

  // Bring the asynchronous pin into the clk domain; only sync2_r is used below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sw.sw_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM with registered level and edge pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= STABLE_LOW;
      cnt_r   <= CNT_ZERO;
      clean_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        STABLE_LOW: begin
          if (sync2_r) begin
            state_r <= WAIT_HIGH;
            cnt_r   <= CNT_ZERO;
          end
        end
        WAIT_HIGH: begin
          if (!sync2_r) begin
            state_r <= STABLE_LOW;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= STABLE_HIGH;
            clean_r <= 1'b1;
            rise_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!sync2_r) begin
            state_r <= WAIT_LOW;
            cnt_r   <= CNT_ZERO;
          end
        end
        WAIT_LOW: begin
          // A return to high is a bounce: the accepted level never left 1.
          if (sync2_r) begin
            state_r <= STABLE_HIGH;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= STABLE_LOW;
            clean_r <= 1'b0;
            fall_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= STABLE_LOW;
          cnt_r   <= CNT_ZERO;
          clean_r <= 1'b0;
        end
      endcase
    end
  end

  assign sw.sw_clean   = clean_r;
  assign sw.rise_pulse = rise_r;
  assign sw.fall_pulse = fall_r;
  assign sw.state_dbg  = state_r;

endmodule
